// File: rtl/rsa_modexp_if.sv
// rsa_modexp_if -- handshake and operand bus of the modular exponentiation engine.
//
// Signals:
//   en          clock enable; while low the engine freezes completely
//   start       request a new operation (honoured only when the engine is idle)
//   M_i/E_i/N_i base, exponent and modulus, sampled on the accepted start edge
//   R_o         result, held until the next completion
//   eoc         one-enabled-cycle completion pulse, R_o valid with it
//   busy        operation in flight (start edge through the eoc cycle)
//   err         operand-range error flag, valid with eoc
//
// Modports: master drives the request side (test bench or upstream
// controller); slave is the engine itself.
interface rsa_modexp_if;
    logic       en;
    logic       start;
    logic [9:0] M_i;
    logic [9:0] E_i;
    logic [9:0] N_i;
    logic [9:0] R_o;
    logic       eoc;
    logic       busy;
    logic       err;

    modport master (
        output en, start, M_i, E_i, N_i,
        input  R_o, eoc, busy, err
    );

    modport slave (
        input  en, start, M_i, E_i, N_i,
        output R_o, eoc, busy, err
    );
endinterface

// File: rtl/rsa_modexp.sv
// rsa_modexp -- iterative 10-bit modular exponentiation R = M^E mod N.
//
// LSB-first square-and-multiply. Each exponent bit costs one 10-step
// interleaved modular multiply (R*B) followed by one 10-step square (B*B),
// so latency is a fixed 200 enabled cycles from the start edge to eoc,
// whatever the operand values. The multiply result is discarded when the
// exponent bit is 0, which keeps the timing data-independent.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (wins over start)
//   bus   rsa_modexp_if.slave: en, start, M_i, E_i, N_i in; R_o, eoc, busy, err out
//
// Optional feature macro: RSA_MODEXP_RANGE_CHECK_EN
//   defined   : N<2 or M>=N at the start edge skips the computation, gives
//               R_o=0 and err=1 with eoc one cycle later; err holds until the
//               next start or reset.
//   undefined : err is tied to 0 and operands are not checked.
module rsa_modexp (
    input  logic         clk,
    input  logic         rst,
    rsa_modexp_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, SQR, DONE} state_t;

    state_t     state_q, state_d;
    logic [9:0] e_q, e_d;          // latched exponent
    logic [9:0] n_q, n_d;          // latched modulus
    logic [9:0] b_q, b_d;          // running base (M^(2^i))
    logic [9:0] r_q, r_d;          // running result
    logic [9:0] p_q, p_d;          // multiplier partial product, kept below N
    logic [9:0] r_out_q, r_out_d;  // visible result register
    logic [3:0] i_q, i_d;          // exponent bit index
    logic [3:0] j_q, j_d;          // multiplier step, MSB first
    logic       eoc_q, eoc_d;
    logic       busy_q, busy_d;
`ifdef RSA_MODEXP_RANGE_CHECK_EN
    logic       err_q, err_d;
    logic       range_bad;
    assign range_bad = (bus.N_i < 10'd2) || (bus.M_i >= bus.N_i);
`endif

    // One interleaved-multiplier step. The multiplicand bit comes from R in
    // MUL and from B in SQR; B is the other operand in both cases.
    // 2P+B < 3N <= 3069 fits in 12 bits, and two conditional subtracts
    // bring it back below N in a single cycle.
    logic        a_bit;
    logic [11:0] n_ext, acc_dbl, acc_s1, acc_s2;
    logic [9:0]  step;

    assign a_bit   = (state_q == MUL) ? r_q[j_q] : b_q[j_q];
    assign n_ext   = {2'b00, n_q};
    assign acc_dbl = {1'b0, p_q, 1'b0} + (a_bit ? {2'b00, b_q} : 12'd0);
    assign acc_s1  = (acc_dbl >= n_ext) ? (acc_dbl - n_ext) : acc_dbl;
    assign acc_s2  = (acc_s1 >= n_ext) ? (acc_s1 - n_ext) : acc_s1;
    // Upper bits are zero for in-range operands; truncation only matters for
    // out-of-range inputs whose result is unspecified anyway.
    assign step    = 10'(acc_s2);

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        n_d     = n_q;
        b_d     = b_q;
        r_d     = r_q;
        p_d     = p_q;
        r_out_d = r_out_q;
        i_d     = i_q;
        j_d     = j_q;
        eoc_d   = eoc_q;
        busy_d  = busy_q;
`ifdef RSA_MODEXP_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    e_d     = bus.E_i;
                    n_d     = bus.N_i;
                    b_d     = bus.M_i;
                    r_d     = 10'd1;
                    p_d     = 10'd0;
                    i_d     = 4'd0;
                    j_d     = 4'd9;
                    busy_d  = 1'b1;
                    state_d = MUL;
`ifdef RSA_MODEXP_RANGE_CHECK_EN
                    err_d   = range_bad;
                    if (range_bad) begin
                        // Result forced to 0; DONE publishes it one cycle later.
                        r_d     = 10'd0;
                        state_d = DONE;
                    end
`endif
                end
            end
            MUL: begin
                p_d = step;
                j_d = j_q - 4'd1;
                if (j_q == 4'd0) begin
                    if (e_q[i_q]) begin
                        r_d = step;
                    end
                    p_d     = 10'd0;
                    j_d     = 4'd9;
                    state_d = SQR;
                end
            end
            SQR: begin
                p_d = step;
                j_d = j_q - 4'd1;
                if (j_q == 4'd0) begin
                    b_d = step;
                    p_d = 10'd0;
                    j_d = 4'd9;
                    if (i_q == 4'd9) begin
                        // Final square never changes R, so publish it now.
                        r_out_d = r_q;
                        eoc_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + 4'd1;
                        state_d = MUL;
                    end
                end
            end
            DONE: begin
                if (!eoc_q) begin
                    // Entered straight from IDLE (rejected operands).
                    r_out_d = r_q;
                    eoc_d   = 1'b1;
                end else begin
                    eoc_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            e_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            p_q     <= '0;
            r_out_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            eoc_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RSA_MODEXP_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (bus.en) begin
            state_q <= state_d;
            e_q     <= e_d;
            n_q     <= n_d;
            b_q     <= b_d;
            r_q     <= r_d;
            p_q     <= p_d;
            r_out_q <= r_out_d;
            i_q     <= i_d;
            j_q     <= j_d;
            eoc_q   <= eoc_d;
            busy_q  <= busy_d;
`ifdef RSA_MODEXP_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.R_o  = r_out_q;
    assign bus.eoc  = eoc_q;
    assign bus.busy = busy_q;
`ifdef RSA_MODEXP_RANGE_CHECK_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif
endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp -- directed, table-driven bench for rsa_modexp.
// Each vector is applied with a stray start pulse mid-operation and the
// operand inputs scrambled after the start edge; result, err and latency
// are checked, then the eoc/busy drop one cycle later. Hand-written
// sequences cover reset mid-operation and the optional range check.
module tb_rsa_modexp;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rsa_modexp_if bus ();

    rsa_modexp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] m;
        logic [9:0] e;
        logic [9:0] n;
        logic [9:0] r;
        int         stall_at;
        int         stall_len;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after a clock edge. Returns latency in edges from the start
    // edge to the edge that raised eoc (-1 on timeout).
    task automatic run_op(input logic [9:0] m, input logic [9:0] e, input logic [9:0] n,
                          input int stall_at, input int stall_len,
                          output logic [9:0] r, output logic er, output int lat);
        int edges;
        bit got;
        bus.M_i   = m;
        bus.E_i   = e;
        bus.N_i   = n;
        bus.en    = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.M_i   = ~m;
        bus.E_i   = ~e;
        bus.N_i   = n ^ 10'h155;
        chk("busy_after_start", int'(bus.busy), 1);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 400) begin
            @(posedge clk); edges++; #1;
            if (bus.eoc) begin
                got = 1'b1;
            end else begin
                bus.en    = (edges >= stall_at && edges < stall_at + stall_len) ? 1'b0 : 1'b1;
                bus.start = (edges == 50) ? 1'b1 : 1'b0;
            end
        end
        bus.en    = 1'b1;
        bus.start = 1'b0;
        lat = got ? edges : -1;
        r   = bus.R_o;
        er  = bus.err;
        @(posedge clk); #1;
        chk("eoc_cleared", int'(bus.eoc), 0);
        chk("busy_cleared", int'(bus.busy), 0);
    endtask

    initial begin
        logic [9:0] r;
        logic       er;
        int         lat;
        checks = 0;
        errors = 0;

        vecs[0] = '{10'd42,   10'd7,   10'd143,  10'd81,  -10, 0};
        vecs[1] = '{10'd81,   10'd103, 10'd143,  10'd42,  -10, 0};
        vecs[2] = '{10'd4,    10'd13,  10'd497,  10'd445, -10, 0};
        vecs[3] = '{10'd1022, 10'd2,   10'd1023, 10'd1,   -10, 0};
        vecs[4] = '{10'd42,   10'd0,   10'd143,  10'd1,   -10, 0};
        vecs[5] = '{10'd0,    10'd5,   10'd143,  10'd0,   -10, 0};
        vecs[6] = '{10'd42,   10'd7,   10'd143,  10'd81,   60, 37};

        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.start = 1'b0;
        bus.M_i   = '0;
        bus.E_i   = '0;
        bus.N_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_R_o", int'(bus.R_o), 0);
        chk("reset_eoc", int'(bus.eoc), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_err", int'(bus.err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            run_op(vecs[k].m, vecs[k].e, vecs[k].n, vecs[k].stall_at, vecs[k].stall_len, r, er, lat);
            $display("vec %0d: M=%0d E=%0d N=%0d -> R=%0d err=%0d latency=%0d",
                     k, vecs[k].m, vecs[k].e, vecs[k].n, r, er, lat);
            chk("result", int'(r), int'(vecs[k].r));
            chk("err", int'(er), 0);
            chk("latency", lat, 200 + vecs[k].stall_len);
        end

        // Reset in the middle of an operation; R_o holds 81 from the last vector.
        bus.M_i   = 10'd4;
        bus.E_i   = 10'd13;
        bus.N_i   = 10'd497;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset mid-op: R_o=%0d eoc=%0d busy=%0d", bus.R_o, bus.eoc, bus.busy);
        chk("midrst_R_o", int'(bus.R_o), 0);
        chk("midrst_eoc", int'(bus.eoc), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        run_op(10'd4, 10'd13, 10'd497, -10, 0, r, er, lat);
        $display("after reset: R=%0d latency=%0d", r, lat);
        chk("postrst_result", int'(r), 445);
        chk("postrst_latency", lat, 200);

`ifdef RSA_MODEXP_RANGE_CHECK_EN
        for (int k = 0; k < 2; k++) begin
            int edges;
            bus.M_i   = (k == 0) ? 10'd42 : 10'd200;
            bus.N_i   = (k == 0) ? 10'd1  : 10'd143;
            bus.E_i   = 10'd7;
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            edges = 0;
            while (edges < 10) begin
                @(posedge clk); edges++; #1;
                if (bus.eoc) break;
            end
            $display("range case %0d: edges=%0d R_o=%0d err=%0d", k, edges, bus.R_o, bus.err);
            chk("range_latency", edges, 1);
            chk("range_R_o", int'(bus.R_o), 0);
            chk("range_err", int'(bus.err), 1);
            @(posedge clk); #1;
            chk("range_eoc_cleared", int'(bus.eoc), 0);
            chk("range_busy_cleared", int'(bus.busy), 0);
            chk("range_err_held", int'(bus.err), 1);
        end
        run_op(10'd42, 10'd7, 10'd143, -10, 0, r, er, lat);
        $display("valid after range error: R=%0d err=%0d", r, er);
        chk("range_clear_err", int'(er), 0);
        chk("range_clear_result", int'(r), 81);
`else
        run_op(10'd200, 10'd7, 10'd143, -10, 0, r, er, lat);
        $display("out-of-range unchecked: R=%0d err=%0d latency=%0d", r, er, lat);
        chk("nocheck_err", int'(er), 0);
        chk("nocheck_latency", lat, 200);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Iterative 10-bit modular exponentiation engine computing R = M^E mod N with square-and-multiply over a bit-serial interleaved modular multiplier. It is the compute stage directly upstream of the crypt result register. Its `R_o`/`eoc` pair drives that register's `R_i`/`eoc` inputs, and both blocks share `en`. Latency is fixed and data-independent: every exponent bit costs one multiply and one square, regardless of its value.

## Interface
- No parameters; datapath width is fixed at 10 bits, with a 12-bit internal accumulator.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: clock enable; when low, all state freezes, including the step counters, `eoc`, `busy` and `err`.
- `start` in 1: request a new operation; honoured only in IDLE with `en`=1.
- `M_i` in 10: message/base, sampled at start.
- `E_i` in 10: exponent, sampled at start.
- `N_i` in 10: modulus, sampled at start.
- `R_o` out 10: result, held until the next completion.
- `eoc` out 1: end-of-conversion; a one-enabled-cycle pulse with `R_o` valid.
- `busy` out 1: high from the start edge until the `eoc` cycle ends.
- `err` out 1: operand-range error, valid with `eoc` (see Configuration).

## Operation
- States: IDLE, MUL, SQR, DONE.
- **Reset values:** state=IDLE; `R_o`=0, `eoc`=0, `busy`=0, `err`=0; all internal registers 0.
- **IDLE + start:**
  - Latch E and N; base B=M; R=1; bit index i=0; step j=9; P=0.
  - Go to MUL.
- **Modular multiply (A×B mod N), 10 steps, MSB first:**
  - Each step: P = 2P + (A[j] ? B : 0); then if P≥N, P−=N; then if P≥N, P−=N.
  - Both conditional subtracts happen in the same cycle.
  - Invariant P<N, hence 2P+B < 3N ≤ 3069, which fits in 12 bits.
- **MUL:** A=R, B=B.
  - After step j=0: if E[i]=1 then R←P, otherwise R is unchanged (constant-time).
  - P←0, j←9, go to SQR.
- **SQR:** A=B, B=B.
  - After step j=0: B←P, P←0, j←9.
  - If i=9, go to DONE; otherwise i←i+1 and go to MUL.
- **DONE:** `R_o`←R; `eoc`=1 for exactly one enabled cycle; then IDLE and `busy`=0.
- **Input handling:**
  - `start` is ignored while not in IDLE.
  - Input changes after the start edge are ignored.
- **Boundary cases:**
  - E=0 gives R=1.
  - M=0 with E≠0 gives R=0.
- **Reset mid-operation:** immediate return to IDLE at the next edge; all outputs go to their reset values; `R_o` clears to 0.
- **`start` and `rst` in the same cycle:** `rst` wins.

## Timing
- The edge sampling `start` is edge 0.
- Edges 1–200 are the 200 multiplier steps (10 bits × (10 MUL + 10 SQR)).
- Edge 200 writes `R_o` and sets `eoc`.
- `eoc` is high between edges 200 and 201; edge 201 clears it and returns to IDLE.
- The earliest accepted next `start` is sampled at edge 202.
- `en`=0 cycles insert stall cycles one-for-one; total latency becomes 200 plus the number of stalled cycles.
- `busy` rises after edge 0 and falls after edge 201.

## Configuration
- **Macro:** `RSA_MODEXP_RANGE_CHECK_EN`.
- **Defined:**
  - At the start edge, if N<2 or M≥N, go straight to DONE: `R_o`=0, `err`=1, `eoc` high between edges 1 and 2.
  - `err` then holds until the next start or reset.
  - Valid operands give `err`=0.
- **Undefined:**
  - `err` is tied to 0 and no checking is done.
  - Out-of-range operands yield deterministic but unspecified `R_o` with normal 200-cycle latency.

## Test plan
- **Encrypt:** M=42, E=7, N=143, start at edge 0 → `eoc` after edge 200, `R_o`=81, `err`=0, `busy` low after edge 201.
- **Decrypt round trip:** M=81, E=103, N=143 → `R_o`=42. Also M=4, E=13, N=497 → `R_o`=445.
- **Boundaries:**
  - M=1022, E=2, N=1023 → `R_o`=1.
  - E=0, N=143 → `R_o`=1.
  - M=0, E=5, N=143 → `R_o`=0.
  - Each completes in exactly 200 cycles.
- **Stall and ignored start:** hold `en` low for 37 cycles mid-operation → `eoc` at start+237 with an identical result. A `start` pulse while `busy` is ignored.
- **Reset mid-operation:** assert `rst` at cycle 120 → `R_o`=0, `eoc`=0, `busy`=0 next cycle. A fresh start then gives the correct result at +200.
- **Range check (macro defined):** N=1 or M=200 with N=143 → `eoc` between edges 1 and 2, `R_o`=0, `err`=1. With the macro undefined → `err` stays 0.
